// File: rtl/sr_latch_driver.sv
// Drives the s/r inputs of a NOR SR latch from two raw push-buttons: synchronise,
// debounce, edge-detect, then emit one fixed-width pulse and verify q afterwards.
module sr_latch_driver #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8,
  parameter int PULSE_W    = 2,
  parameter int GAP_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic err
);

  localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) + 1 : 1;

  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

  // Bit 0 carries the set button, bit 1 the clear button.
  logic [1:0]       sync1_q, sync2_q, deb_q, deb_dly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       ev;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            expect_q, expect_d;
  logic            err_q, err_d;
  logic            s_out_q, r_out_q, busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= {clr_req, set_req};
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      // A level is accepted only after it differs from deb_q for DEB_CYCLES straight cycles.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev = deb_q & ~deb_dly_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    expect_d = expect_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // Simultaneous requests are ambiguous, so both are dropped.
        if (ev[0] && !ev[1]) begin
          state_d  = SET_P;
          expect_d = 1'b1;
        end else if (ev[1] && !ev[0]) begin
          state_d  = CLR_P;
          expect_d = 1'b0;
        end
      end
      SET_P, CLR_P: begin
        if (tcnt_q == TW'(PULSE_W - 1)) begin
          state_d = GAP;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (tcnt_q == TW'(GAP_W - 1)) begin
          state_d = IDLE;
          tcnt_d  = '0;
          if (q_fb != expect_q) err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      expect_q <= 1'b0;
      err_q    <= 1'b0;
      s_out_q  <= 1'b0;
      r_out_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      expect_q <= expect_d;
      err_q    <= err_d;
      s_out_q  <= (state_d == SET_P);
      r_out_q  <= (state_d == CLR_P);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign s_out = s_out_q;
  assign r_out = r_out_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NOR-latch model on q_fb.
// "Edge k" is the k-th rising edge after a button is first driven high.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic q_fb;
  logic s_out, r_out, busy, err;

  logic latch_q = 1'b0;
  logic tie_en  = 1'b0;
  logic tie_val = 1'b0;

  int errors = 0;
  int checks = 0;

  sr_latch_driver #(
    .DEB_CYCLES(4), .CNT_W(8), .PULSE_W(2), .GAP_W(2)
  ) dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
    .s_out(s_out), .r_out(r_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)        latch_q <= 1'b0;
    else if (s_out) latch_q <= 1'b1;
    else if (r_out) latch_q <= 1'b0;
  end

  assign q_fb = tie_en ? tie_val : latch_q;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; set_req = 1'b1; clr_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_out, r_out, busy, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0000", {s_out, r_out, busy, err});
    end
    do_reset();
  endtask

  task automatic test_single_set();
    logic exp_s, exp_b;
    do_reset();
    @(negedge clk);
    set_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp_s = (k == 7 || k == 8);
      exp_b = (k >= 7 && k <= 10);
      checks++;
      if ({s_out, r_out, busy, err} !== {exp_s, 1'b0, exp_b, 1'b0}) begin
        errors++;
        $display("FAIL single_set edge=%0d got s,r,busy,err=%b expected %b",
                 k, {s_out, r_out, busy, err}, {exp_s, 1'b0, exp_b, 1'b0});
      end
    end
    set_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s_out, r_out, busy} !== 3'b000) begin
        errors++;
        $display("FAIL release_no_event cyc=%0d got %b expected 000", k, {s_out, r_out, busy});
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      set_req = (k < 12) ? ((k % 4) < 2) : 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({s_out, r_out, busy} !== 3'b000) begin
        errors++;
        $display("FAIL glitch cyc=%0d got s,r,busy=%b expected 000", k, {s_out, r_out, busy});
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    set_req = 1'b1; clr_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({s_out, r_out, busy} !== 3'b000) begin
        errors++;
        $display("FAIL conflict edge=%0d got s,r,busy=%b expected 000", k, {s_out, r_out, busy});
      end
    end
    @(negedge clk);
    set_req = 1'b0; clr_req = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_err_sticky();
    logic exp_r, exp_e, exp_s;
    do_reset();
    tie_en = 1'b1; tie_val = 1'b1;
    @(negedge clk);
    clr_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      exp_r = (k == 7 || k == 8);
      exp_e = (k >= 11);
      checks++;
      if ({s_out, r_out, err} !== {1'b0, exp_r, exp_e}) begin
        errors++;
        $display("FAIL bad_clear edge=%0d got s,r,err=%b expected %b",
                 k, {s_out, r_out, err}, {1'b0, exp_r, exp_e});
      end
    end
    @(negedge clk);
    clr_req = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    tie_en = 1'b0;
    set_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      exp_s = (k == 7 || k == 8);
      checks++;
      if ({s_out, r_out, err} !== {exp_s, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL err_sticky edge=%0d got s,r,err=%b expected %b",
                 k, {s_out, r_out, err}, {exp_s, 1'b0, 1'b1});
      end
    end
    @(negedge clk);
    rst = 1'b1; set_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_rst got %b expected 0", err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    logic exp_s, exp_b;
    do_reset();
    @(negedge clk);
    set_req = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if ({s_out, busy} !== 2'b11) begin
      errors++;
      $display("FAIL pre_abort got s,busy=%b expected 11", {s_out, busy});
    end
    @(negedge clk);
    rst = 1'b1; set_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort got s,busy=%b expected 00", {s_out, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    set_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_s = (k == 7 || k == 8);
      exp_b = (k >= 7 && k <= 10);
      checks++;
      if ({s_out, busy, err} !== {exp_s, exp_b, 1'b0}) begin
        errors++;
        $display("FAIL after_abort edge=%0d got s,busy,err=%b expected %b",
                 k, {s_out, busy, err}, {exp_s, exp_b, 1'b0});
      end
    end
    @(negedge clk);
    set_req = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // clr_req starts one cycle behind set_req, so its debounced event lands
  // one cycle after s_out rises, while the set sequence is still busy.
  task automatic test_back_to_back();
    logic exp_s;
    do_reset();
    @(negedge clk);
    set_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 1) clr_req = 1'b1;
      exp_s = (k == 7 || k == 8);
      checks++;
      if ((s_out & r_out) !== 1'b0) begin
        errors++;
        $display("FAIL s_and_r edge=%0d got s=%b r=%b expected not both", k, s_out, r_out);
      end
      checks++;
      if ({s_out, r_out} !== {exp_s, 1'b0}) begin
        errors++;
        $display("FAIL busy_discard edge=%0d got s,r=%b expected %b", k, {s_out, r_out}, {exp_s, 1'b0});
      end
    end
    @(negedge clk);
    set_req = 1'b0; clr_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_glitch();
    test_conflict();
    test_err_sticky();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
